alu_iterative: RTL and testbench

- Parametrised multi-cycle ALU for the GPU core execute stage. Successor to the single-cycle 8-bit core ALU.
- Width is configurable. Adds a MOD op, a signed-compare option, and an undefined-op error flag.
- MUL and DIV/MOD are iterative (one bit per cycle) and use a valid/ready handshake in place of core-state gating.
- Division by zero is deterministic: all-ones result plus an error flag. It never produces X.
- Sits between the register file read and the writeback mux. One operation is in flight at a time.

---
 rtl/alu_iterative.sv | 188 ++++++++++++++++++
 tb/tb_alu_iterative.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_iterative.sv
// alu_iterative: multi-cycle ALU for the execute stage.
// ADD/SUB/CMP and error cases finish in one cycle. MUL (shift-add) and
// DIV/MOD (restoring division) take one bit per cycle. One op is in flight
// at a time, with valid/ready handshakes on both the input and output sides.
module alu_iterative #(
    parameter int DATA_WIDTH = 8,
    parameter int SIGNED_CMP = 0,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] rs,
    input  logic [DATA_WIDTH-1:0] rt,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  div_zero,
    output logic                  op_err
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_MOD = 3'b100;
    localparam logic [2:0] OP_CMP = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q;
    logic [2:0]            op_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic [DATA_WIDTH-1:0] acc_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic                  div_zero_q;
    logic                  op_err_q;
    logic                  in_ready_q;
    logic                  out_valid_q;

    logic [DATA_WIDTH-1:0] quickResult;
    logic                  quickDivZero;
    logic                  quickOpErr;
    logic                  startsIter;
    logic                  cmpLess;
    logic                  cmpEqual;

    logic [DATA_WIDTH-1:0] mulAcc_d;
    logic [DATA_WIDTH:0]   remShift;
    logic                  divFits;
    logic [DATA_WIDTH-1:0] divRem_d;
    logic [DATA_WIDTH-1:0] divQuo_d;

    // Single-cycle results for the op currently on the inputs, plus the
    // decision whether it needs the iterative datapath instead.
    always_comb begin
        quickResult  = '0;
        quickDivZero = 1'b0;
        quickOpErr   = 1'b0;
        cmpEqual     = (rs == rt);
        if (SIGNED_CMP != 0) begin
            cmpLess = ($signed(rs) < $signed(rt));
        end else begin
            cmpLess = (rs < rt);
        end
        startsIter = (op == OP_MUL) ||
                     (((op == OP_DIV) || (op == OP_MOD)) && (rt != '0));
        case (op)
            OP_ADD: quickResult = rs + rt;
            OP_SUB: quickResult = rs - rt;
            OP_DIV, OP_MOD: begin
                quickResult  = '1;
                quickDivZero = (rt == '0);
            end
            OP_CMP: quickResult = {{(DATA_WIDTH-3){1'b0}}, cmpLess, cmpEqual,
                                   !cmpLess && !cmpEqual};
            OP_MUL: quickResult = '0;
            default: quickOpErr = 1'b1;
        endcase
    end

    // One iteration step: shift-add for MUL, restore-or-subtract for DIV/MOD.
    // For division a_q shifts the dividend out of its top while the quotient
    // bits shift in at the bottom; acc_q holds the partial remainder.
    always_comb begin
        mulAcc_d = b_q[0] ? (acc_q + a_q) : acc_q;
        remShift = {acc_q, a_q[DATA_WIDTH-1]};
        divFits  = (remShift >= {1'b0, b_q});
        divRem_d = divFits ? (remShift[DATA_WIDTH-1:0] - b_q) : remShift[DATA_WIDTH-1:0];
        divQuo_d = {a_q[DATA_WIDTH-2:0], divFits};
    end

    // Control FSM with registered handshake outputs and result/flag holding.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            div_zero_q  <= 1'b0;
            op_err_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_q       <= op;
                        a_q        <= rs;
                        b_q        <= rt;
                        acc_q      <= '0;
                        in_ready_q <= 1'b0;
                        if (startsIter) begin
                            cnt_q      <= CNT_WIDTH'(DATA_WIDTH);
                            div_zero_q <= 1'b0;
                            op_err_q   <= 1'b0;
                            state_q    <= BUSY;
                        end else begin
                            result_q    <= quickResult;
                            div_zero_q  <= quickDivZero;
                            op_err_q    <= quickOpErr;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q - CNT_WIDTH'(1);
                    if (op_q == OP_MUL) begin
                        acc_q <= mulAcc_d;
                        a_q   <= a_q << 1;
                        b_q   <= b_q >> 1;
                    end else begin
                        acc_q <= divRem_d;
                        a_q   <= divQuo_d;
                    end
                    if (cnt_q == CNT_WIDTH'(1)) begin
                        if (op_q == OP_MUL) begin
                            result_q <= mulAcc_d;
                        end else if (op_q == OP_DIV) begin
                            result_q <= divQuo_d;
                        end else begin
                            result_q <= divRem_d;
                        end
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign div_zero  = div_zero_q;
    assign op_err    = op_err_q;

endmodule

// File: tb/tb_alu_iterative.sv
// tb_alu_iterative: scoreboard bench for alu_iterative. A driver issues ops
// and queues the expected response from an arithmetic reference model; a
// monitor compares whenever the DUT presents a result. A second instance
// with signed compare enabled covers the signed CMP path.
module tb_alu_iterative;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] rs;
    logic [W-1:0] rt;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         div_zero;
    logic         op_err;

    logic         sInValid;
    logic         sInReady;
    logic [2:0]   sOp;
    logic [W-1:0] sRs;
    logic [W-1:0] sRt;
    logic         sOutValid;
    logic [W-1:0] sResult;
    logic         sDivZero;
    logic         sOpErr;

    typedef struct {
        int res;
        bit dz;
        bit oe;
        int lat;
        int acceptCycle;
    } expT;

    expT expQ[$];
    int  checks      = 0;
    int  errors      = 0;
    int  cycleCount  = 0;
    int  readyPct    = 100;
    bit  forceLow    = 1'b0;
    bit  expectBusy  = 1'b0;
    bit  prevValid   = 1'b0;

    alu_iterative #(.DATA_WIDTH(W), .SIGNED_CMP(0)) u_dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .op(op), .rs(rs), .rt(rt),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .div_zero(div_zero), .op_err(op_err)
    );

    alu_iterative #(.DATA_WIDTH(W), .SIGNED_CMP(1)) u_dutSigned (
        .clk(clk), .reset(reset), .flush(1'b0),
        .in_valid(sInValid), .in_ready(sInReady), .op(sOp), .rs(sRs), .rt(sRt),
        .out_valid(sOutValid), .out_ready(1'b1), .result(sResult),
        .div_zero(sDivZero), .op_err(sOpErr)
    );

    // Reference behaviour computed with plain integer arithmetic.
    function automatic expT model(input int o, input int a, input int b, input bit signedMode);
        expT e;
        int  m;
        int  sa;
        int  sb;
        m = 1 << W;
        e.res = 0; e.dz = 1'b0; e.oe = 1'b0; e.lat = 1; e.acceptCycle = 0;
        case (o)
            0: e.res = (a + b) % m;
            1: e.res = (a - b + m) % m;
            2: begin e.res = (a * b) % m; e.lat = W + 1; end
            3, 4: begin
                if (b == 0) begin
                    e.res = m - 1;
                    e.dz  = 1'b1;
                end else begin
                    e.res = (o == 3) ? a / b : a % b;
                    e.lat = W + 1;
                end
            end
            5: begin
                sa = a; sb = b;
                if (signedMode) begin
                    if (sa >= m / 2) sa = sa - m;
                    if (sb >= m / 2) sb = sb - m;
                end
                e.res = (sa < sb) ? 4 : ((sa == sb) ? 2 : 1);
            end
            default: e.oe = 1'b1;
        endcase
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Issue one op: hold in_valid until the DUT is idle, then scramble inputs.
    task automatic applyStimulus(input logic [2:0] o, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input bit track);
        int  waitCnt;
        expT e;
        waitCnt = 0;
        @(negedge clk);
        op = o; rs = a; rt = b; in_valid = 1'b1;
        while (!in_ready && waitCnt < 500) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: in_ready got 0 expected 1");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (track) begin
            e = model(int'(o), int'(a), int'(b), 1'b0);
            e.acceptCycle = cycleCount;
            expQ.push_back(e);
        end
        expectBusy = 1'b1;
        in_valid = 1'b0;
        op = 3'($urandom);
        rs = W'($urandom);
        rt = W'($urandom);
    endtask

    task automatic drainQueue();
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: pending got %0d expected 0", expQ.size());
            expQ.delete();
        end
    endtask

    // One CMP on the signed-compare instance, checked one edge after accept.
    task automatic checkSigned(input logic [W-1:0] a, input logic [W-1:0] b);
        expT e;
        e = model(5, int'(a), int'(b), 1'b1);
        @(negedge clk);
        checkOutput("scmp_in_ready", sInReady, 1);
        sOp = 3'b101; sRs = a; sRt = b; sInValid = 1'b1;
        @(posedge clk);
        #1;
        sInValid = 1'b0;
        @(negedge clk);
        checkOutput("scmp_valid", sOutValid, 1);
        checkOutput("scmp_result", sResult, e.res);
        checkOutput("scmp_flags", {sDivZero, sOpErr}, 0);
        @(posedge clk);
    endtask

    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Consumer-side readiness, updated just after each edge.
    always @(posedge clk) begin
        #2;
        out_ready = forceLow ? 1'b0 : ($urandom_range(99) < readyPct);
    end

    // Monitor: compare whatever the DUT presents against the queue head.
    always @(negedge clk) begin
        if (!reset) begin
            if (expectBusy && !out_valid) checkOutput("in_ready_busy", in_ready, 0);
            if (out_valid) begin
                expectBusy = 1'b0;
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_output: got result %0d expected no out_valid", result);
                end else begin
                    if (!prevValid)
                        checkOutput("latency", cycleCount - expQ[0].acceptCycle + 1, expQ[0].lat);
                    checkOutput("result", result, expQ[0].res);
                    checkOutput("div_zero", div_zero, expQ[0].dz);
                    checkOutput("op_err", op_err, expQ[0].oe);
                    if (out_ready) void'(expQ.pop_front());
                end
            end
            prevValid = out_valid;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  n;
        logic [2:0]   o;
        logic [W-1:0] a;
        logic [W-1:0] b;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; op = '0; rs = '0; rt = '0;
        sInValid = 1'b0; sOp = '0; sRs = '0; sRt = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_result", result, 0);
        checkOutput("rst_flags", {div_zero, op_err}, 0);
        reset = 1'b0;

        // Directed arithmetic and boundary cases.
        applyStimulus(3'b000, 8'd250, 8'd10, 1'b1);
        applyStimulus(3'b001, 8'd3, 8'd5, 1'b1);
        applyStimulus(3'b101, 8'd3, 8'd5, 1'b1);
        applyStimulus(3'b101, 8'hFF, 8'd1, 1'b1);
        applyStimulus(3'b010, 8'd13, 8'd11, 1'b1);
        applyStimulus(3'b010, 8'd16, 8'd16, 1'b1);
        applyStimulus(3'b011, 8'd200, 8'd7, 1'b1);
        applyStimulus(3'b100, 8'd200, 8'd7, 1'b1);
        applyStimulus(3'b011, 8'd9, 8'd0, 1'b1);
        applyStimulus(3'b111, 8'd12, 8'd0, 1'b1);
        applyStimulus(3'b110, 8'd77, 8'd3, 1'b1);
        drainQueue();

        // Signed compare instance.
        checkSigned(8'hFF, 8'd1);
        checkSigned(8'd3, 8'd5);
        checkSigned(8'h80, 8'h7F);
        checkSigned(8'd7, 8'd7);
        for (int i = 0; i < 6; i++) checkSigned(W'($urandom), W'($urandom));

        // Backpressure: result held while out_ready is low, in_valid ignored.
        forceLow = 1'b1;
        applyStimulus(3'b011, 8'd100, 8'd3, 1'b1);
        n = 0;
        while (!out_valid && n < 50) begin @(negedge clk); n++; end
        checkOutput("bp_valid_seen", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_valid_held", out_valid, 1);
            in_valid = 1'b1; op = 3'b000; rs = W'($urandom); rt = W'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0;
        forceLow = 1'b0;
        n = 0;
        while (!(out_valid && out_ready) && n < 20) begin @(negedge clk); n++; end
        @(posedge clk);
        #1;
        checkOutput("bp_idle_ready", in_ready, 1);
        checkOutput("bp_idle_valid", out_valid, 0);
        drainQueue();

        // Flush on the third BUSY cycle of a division.
        applyStimulus(3'b011, 8'd255, 8'd2, 1'b0);
        repeat (3) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        expectBusy = 1'b0;
        checkOutput("flush_in_ready", in_ready, 1);
        checkOutput("flush_out_valid", out_valid, 0);
        repeat (12) @(negedge clk);

        // Flush together with in_valid in IDLE drops the op.
        @(negedge clk);
        in_valid = 1'b1; op = 3'b000; rs = 8'd5; rt = 8'd6; flush = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; flush = 1'b0;
        checkOutput("flush_drop_ready", in_ready, 1);
        repeat (5) @(negedge clk);

        // Reset in the middle of a multiply.
        applyStimulus(3'b010, 8'd200, 8'd3, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        expectBusy = 1'b0;
        checkOutput("midrst_in_ready", in_ready, 1);
        checkOutput("midrst_out_valid", out_valid, 0);
        checkOutput("midrst_result", result, 0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(3'b000, 8'd1, 8'd1, 1'b1);
        drainQueue();

        // Randomized traffic with random consumer backpressure.
        readyPct = 60;
        for (int i = 0; i < 80; i++) begin
            o = 3'($urandom_range(7));
            a = W'($urandom);
            b = ($urandom_range(5) == 0) ? '0 : W'($urandom);
            applyStimulus(o, a, b, 1'b1);
        end
        drainQueue();
        readyPct = 100;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
